// File: rtl/arbiter_requester.sv
// Requester-side agent for the 4-way arbiter request/grant protocol.
// Define ARB_REQ_TIMEOUT_EN to enable the REQ timeout and starve flags.
module arbiter_requester #(
    parameter int LEN_W    = 4,
    parameter int WAIT_W   = 8,
    parameter int MAX_WAIT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           start,
    input  logic [4*LEN_W-1:0]   len,
    output logic                 ra,
    output logic                 rb,
    output logic                 rc,
    output logic                 rd,
    input  logic                 ga,
    input  logic                 gb,
    input  logic                 gc,
    input  logic                 gd,
    output logic [3:0]           busy,
    output logic [3:0]           done,
    output logic                 proto_err,
    output logic [WAIT_W-1:0]    max_wait,
    output logic [3:0]           starve
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] OWN  = 2'd2;
    localparam logic [1:0] REL  = 2'd3;

    localparam logic [LEN_W-1:0]  LEN_ONE = LEN_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_SAT = '1;

    logic [3:0]              g;
    logic [3:0]              r_q;
    logic [3:0]              r_n;
    logic [3:0]              busy_n;
    logic [3:0]              done_n;
    logic                    multi;
    logic                    err_n;
    logic [WAIT_W-1:0]       mw_n;
    logic [LEN_W-1:0]        li;

    logic [3:0][1:0]         st;
    logic [3:0][1:0]         st_n;
    logic [3:0][LEN_W-1:0]   rem;
    logic [3:0][LEN_W-1:0]   rem_n;
    logic [3:0][WAIT_W-1:0]  wt;
    logic [3:0][WAIT_W-1:0]  wt_n;

`ifdef ARB_REQ_TIMEOUT_EN
    localparam logic [WAIT_W-1:0] TMO = WAIT_W'(MAX_WAIT - 1);
    logic [3:0] stv_q;
    logic [3:0] stv_n;
`endif

    assign g = {gd, gc, gb, ga};
    assign {rd, rc, rb, ra} = r_q;
    assign multi = (g & (g - 4'd1)) != 4'd0;

    always_comb begin
        err_n  = proto_err | multi;
        mw_n   = max_wait;
        st_n   = st;
        rem_n  = rem;
        wt_n   = wt;
        done_n = '0;
        r_n    = '0;
        busy_n = '0;
        li     = '0;
`ifdef ARB_REQ_TIMEOUT_EN
        stv_n  = stv_q;
`endif
        for (int i = 0; i < 4; i++) begin
            li = len[i*LEN_W +: LEN_W];
            unique case (st[i])
                IDLE: begin
                    if (g[i]) err_n = 1'b1;
                    if (start[i]) begin
                        st_n[i]  = REQ;
                        rem_n[i] = (li == '0) ? LEN_ONE : li;
                        wt_n[i]  = '0;
                    end
                end
                REQ: begin
                    if (g[i]) begin
                        // first granted cycle is also the first tenure cycle
                        if (wt[i] > mw_n) mw_n = wt[i];
                        if (rem[i] == LEN_ONE) begin
                            st_n[i]   = REL;
                            done_n[i] = 1'b1;
                        end else begin
                            st_n[i]  = OWN;
                            rem_n[i] = rem[i] - LEN_ONE;
                        end
                    end else begin
                        if (wt[i] != WAIT_SAT) wt_n[i] = wt[i] + 1'b1;
`ifdef ARB_REQ_TIMEOUT_EN
                        if (wt[i] == TMO) begin
                            st_n[i]  = REL;
                            stv_n[i] = 1'b1;
                        end
`endif
                    end
                end
                OWN: begin
                    if (g[i]) begin
                        if (rem[i] == LEN_ONE) begin
                            st_n[i]   = REL;
                            done_n[i] = 1'b1;
                        end else begin
                            rem_n[i] = rem[i] - LEN_ONE;
                        end
                    end else begin
                        err_n   = 1'b1;
                        st_n[i] = REL;
                    end
                end
                default: st_n[i] = IDLE;
            endcase
            r_n[i]    = (st_n[i] == REQ) || (st_n[i] == OWN);
            busy_n[i] = st_n[i] != IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= '0;
            rem       <= '0;
            wt        <= '0;
            r_q       <= '0;
            busy      <= '0;
            done      <= '0;
            proto_err <= 1'b0;
            max_wait  <= '0;
        end else begin
            st        <= st_n;
            rem       <= rem_n;
            wt        <= wt_n;
            r_q       <= r_n;
            busy      <= busy_n;
            done      <= done_n;
            proto_err <= err_n;
            max_wait  <= mw_n;
        end
    end

`ifdef ARB_REQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) stv_q <= '0;
        else       stv_q <= stv_n;
    end
    assign starve = stv_q;
`else
    assign starve = 4'b0000;
`endif

endmodule

// File: tb/tb_arbiter_requester.sv
// Scoreboard bench for arbiter_requester: directed tenures,
// round-robin arbiter model, protocol faults and timeout.
module tb_arbiter_requester;

    localparam int LEN_W  = 4;
    localparam int WAIT_W = 8;

    logic              clk;
    logic              reset;
    logic [3:0]        start;
    logic [4*LEN_W-1:0] len;
    logic              ra, rb, rc, rd;
    logic              ga, gb, gc, gd;
    logic [3:0]        busy, done, starve;
    logic              proto_err;
    logic [WAIT_W-1:0] max_wait;

    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] man_g;
    logic [3:0] arb_g;
    logic       arb_en;

    typedef struct {
        int ch;
        int len;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   passes;
    int   total;
    int   ovl[4];

    arbiter_requester #(
        .LEN_W(LEN_W), .WAIT_W(WAIT_W), .MAX_WAIT(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .ra(ra), .rb(rb), .rc(rc), .rd(rd),
        .ga(ga), .gb(gb), .gc(gc), .gd(gd),
        .busy(busy), .done(done), .proto_err(proto_err),
        .max_wait(max_wait), .starve(starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign r = {rd, rc, rb, ra};
    assign g = arb_en ? arb_g : man_g;
    assign {gd, gc, gb, ga} = g;

    // round-robin arbiter model: owner keeps grant while requesting
    logic [1:0] own, last, sel;
    logic       own_v, sel_v;

    always_comb begin
        sel   = 2'd0;
        sel_v = 1'b0;
        if (own_v && r[own]) begin
            sel   = own;
            sel_v = 1'b1;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                if (!sel_v && r[2'(int'(last) + k)]) begin
                    sel   = 2'(int'(last) + k);
                    sel_v = 1'b1;
                end
            end
        end
        arb_g = sel_v ? (4'd1 << sel) : 4'd0;
    end

    always @(posedge clk) begin
        if (reset) begin
            own_v <= 1'b0;
            own   <= 2'd0;
            last  <= 2'd3;
        end else begin
            own_v <= sel_v;
            if (sel_v) begin
                own  <= sel;
                last <= sel;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        man_g = '0;
        start = '0;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    // monitor: tally r&g per channel, pop on every done pulse
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                ovl[i] = 0;
            end else begin
                if (r[i] && g[i]) ovl[i]++;
                if (done[i]) begin
                    if (q.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_done: ch %0d got pulse expected none", i);
                    end else begin
                        me = q.pop_front();
                        chk("done_ch", i, me.ch);
                        chk("done_tenure", ovl[i], me.len);
                        chk("done_r_low", int'(r[i]), 0);
                    end
                    ovl[i] = 0;
                end
            end
        end
    end

    // start one channel, grant dly cycles after r rises, hold until r drops
    task automatic run_ch(input int ch, input int l, input int dly,
                          output int hi);
        int bound;
        q.push_back('{ch, (l == 0) ? 1 : l});
        len[ch*LEN_W +: LEN_W] = LEN_W'(l);
        start[ch] = 1'b1;
        tick();
        start[ch] = 1'b0;
        hi = 0;
        repeat (dly) begin
            if (r[ch]) hi++;
            tick();
        end
        man_g[ch] = 1'b1;
        bound = 0;
        while (r[ch] && bound < 50) begin
            hi++;
            bound++;
            tick();
        end
        if (bound >= 50) chk("run_timeout", bound, 0);
        man_g[ch] = 1'b0;
    endtask

    initial begin
        int hi;
        int ok;
        passes = 0;
        total  = 0;
        arb_en = 1'b0;
        len    = '0;
        do_reset(3);

        chk("rst_outs", int'({r, busy, done, proto_err, starve}), 0);
        chk("rst_max_wait", int'(max_wait), 0);

        // reset mid-tenure on ch a
        len[3:0] = 4'd8;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        man_g[0] = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        man_g = '0;
        tick();
        reset = 1'b0;
        chk("midreset_ra", int'(ra), 0);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_err", int'(proto_err), 0);

        // len=3, grant 2 cycles after ra
        run_ch(0, 3, 2, hi);
        chk("ra_high_cycles", hi, 5);
        tick();
        chk("max_wait_t2", int'(max_wait), 2);
        chk("err_t2", int'(proto_err), 0);

        // len=0 behaves as 1
        run_ch(3, 0, 0, hi);
        chk("rd_high_len0", hi, 1);
        tick();
        chk("max_wait_len0", int'(max_wait), 2);
        chk("busy_idle", int'(busy), 0);

        // all four at once under round-robin arbitration
        do_reset(1);
        arb_en = 1'b1;
        len = {4{4'd2}};
        for (int i = 0; i < 4; i++) q.push_back('{i, 2});
        start = 4'hf;
        tick();
        start = 4'h0;
        repeat (12) tick();
        arb_en = 1'b0;
        chk("rr_max_wait", int'(max_wait), 6);
        chk("rr_err", int'(proto_err), 0);
        chk("rr_busy", int'(busy), 0);
        chk("rr_q_empty", q.size(), 0);

        // two grants in one cycle
        do_reset(1);
        len[3:0] = 4'd1;
        len[7:4] = 4'd1;
        start = 4'b0011;
        tick();
        start = 4'b0000;
        tick();
        q.push_back('{0, 1});
        q.push_back('{1, 1});
        man_g = 4'b0011;
        tick();
        man_g = 4'b0000;
        chk("multi_err", int'(proto_err), 1);
        repeat (5) tick();
        chk("multi_err_sticky", int'(proto_err), 1);
        chk("multi_q_empty", q.size(), 0);
        do_reset(1);
        chk("err_cleared", int'(proto_err), 0);

        // grant dropped in OWN on ch c
        len[11:8] = 4'd4;
        start[2] = 1'b1;
        tick();
        start[2] = 1'b0;
        man_g[2] = 1'b1;
        tick();
        man_g[2] = 1'b0;
        tick();
        chk("drop_rc", int'(rc), 0);
        chk("drop_err", int'(proto_err), 1);
        tick();
        chk("drop_busy", int'(busy[2]), 0);
        repeat (3) tick();
        chk("drop_q_empty", q.size(), 0);

        // ch b never granted
        do_reset(1);
        len[7:4] = 4'd2;
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        repeat (7) tick();
        chk("wait_rb", int'(rb), 1);
        chk("wait_starve", int'(starve), 0);
`ifdef ARB_REQ_TIMEOUT_EN
        tick();
        chk("tmo_starve", int'(starve[1]), 1);
        chk("tmo_rb", int'(rb), 0);
        chk("tmo_busy_rel", int'(busy[1]), 1);
        tick();
        chk("tmo_busy_idle", int'(busy[1]), 0);
        chk("tmo_starve_sticky", int'(starve[1]), 1);
`else
        ok = 1;
        repeat (100) begin
            tick();
            if (!rb) ok = 0;
        end
        chk("rb_held", ok, 1);
        chk("no_starve", int'(starve), 0);
        chk("still_busy", int'(busy[1]), 1);
`endif
        do_reset(1);
        chk("final_outs", int'({r, busy, proto_err, starve}), 0);
        chk("final_q_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
